// File: rtl/mux_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
// Shared definitions for the scanning channel multiplexer:
//   state_t      - controller states (MANUAL, SCAN, HOLD)
//   MODE_*       - encoding of the mode input
//   DCNT_W       - width of the dwell counter
//   sel_width()  - channel index width, never narrower than one bit
// -----------------------------------------------------------------------------
package mux_pkg;

    typedef enum logic [1:0] {
        MANUAL = 2'd0,
        SCAN   = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    localparam int DCNT_W = 8;

    function automatic int sel_width(input int channels);
        return ($clog2(channels) > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/mux_rr_pick.sv
// -----------------------------------------------------------------------------
// mux_rr_pick
// Combinational round-robin search: finds the first valid channel strictly
// after cur_ch, ascending and wrapping CHANNELS-1 -> 0. The current channel
// itself is not a candidate, so found=0 means "no other channel is valid".
// Ports:
//   valid   in  CHANNELS  per-channel valid flags
//   cur_ch  in  SELW      index to search after (always in range)
//   next_ch out SELW      first valid index after cur_ch (cur_ch if none)
//   found   out 1         a different valid channel exists
// -----------------------------------------------------------------------------
module mux_rr_pick #(
    parameter int CHANNELS = 4,
    parameter int SELW     = 2
) (
    input  logic [CHANNELS-1:0] valid,
    input  logic [SELW-1:0]     cur_ch,
    output logic [SELW-1:0]     next_ch,
    output logic                found
);

    always_comb begin
        int unsigned cand;
        logic [SELW-1:0] idx;
        // NOTE: every output and temporary gets a value before any branch so
        // no path leaves a variable unassigned and no latch is inferred.
        next_ch = cur_ch;
        found   = 1'b0;
        cand    = 0;
        idx     = '0;
        // Offsets are visited in ascending order; the first hit wins.
        for (int off = 1; off < CHANNELS; off++) begin
            cand = 32'(cur_ch) + 32'(off);
            if (cand >= 32'(CHANNELS)) begin
                cand = cand - 32'(CHANNELS);
            end
            idx = SELW'(cand);
            if (!found && valid[idx]) begin
                next_ch = idx;
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_n_scan.sv
// -----------------------------------------------------------------------------
// mux_n_scan
// N-channel multiplexer with manual selection and an automatic round-robin
// scan that dwells DWELL cycles on each valid channel.
// Ports:
//   clk           in  1               rising-edge clock
//   rst           in  1               asynchronous active-high reset
//   in_data       in  CHANNELS*WIDTH  channel k at [k*WIDTH +: WIDTH]
//   in_valid      in  CHANNELS        per-channel valid
//   mode          in  1               0 = MANUAL, 1 = SCAN
//   sel           in  SELW            manual channel / scan start channel
//   hold          in  1               freezes the scan position
//   out_data      out WIDTH           registered data of selected channel
//   out_valid     out 1               registered valid of selected channel
//   out_ch        out SELW            registered selected index
//   switch_pulse  out 1               high for the first cycle on a new
//                                     channel reached by the scan
// -----------------------------------------------------------------------------
module mux_n_scan
    import mux_pkg::*;
#(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 4,
    parameter  int DWELL    = 4,
    localparam int SELW     = sel_width(CHANNELS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [CHANNELS*WIDTH-1:0]   in_data,
    input  logic [CHANNELS-1:0]         in_valid,
    input  logic                        mode,
    input  logic [SELW-1:0]             sel,
    input  logic                        hold,
    output logic [WIDTH-1:0]            out_data,
    output logic                        out_valid,
    output logic [SELW-1:0]             out_ch,
    output logic                        switch_pulse
);

    localparam logic [DCNT_W-1:0] DWELL_RELOAD = DCNT_W'(DWELL - 1);
    // One extra bit so the range compare is meaningful for every CHANNELS.
    localparam logic [SELW:0]     CH_LIMIT     = (SELW + 1)'(CHANNELS);

    state_t              state_q, state_d;
    logic [SELW-1:0]     cur_ch_q, cur_ch_d;
    logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
    logic [WIDTH-1:0]    data_d;
    logic                valid_d;
    logic [SELW-1:0]     ch_d;
    logic                pulse_d;

    logic                sel_in_range;
    logic [SELW-1:0]     pick_ch;
    logic                pick_found;
    logic [WIDTH-1:0]    chan_data [CHANNELS];

    for (genvar k = 0; k < CHANNELS; k++) begin : g_unpack
        assign chan_data[k] = in_data[k*WIDTH +: WIDTH];
    end

    assign sel_in_range = ({1'b0, sel} < CH_LIMIT);

    mux_rr_pick #(
        .CHANNELS (CHANNELS),
        .SELW     (SELW)
    ) u_pick (
        .valid   (in_valid),
        .cur_ch  (cur_ch_q),
        .next_ch (pick_ch),
        .found   (pick_found)
    );

    always_comb begin
        state_d  = state_q;
        cur_ch_d = cur_ch_q;
        dcnt_d   = dcnt_q;
        data_d   = '0;
        valid_d  = 1'b0;
        ch_d     = '0;
        pulse_d  = 1'b0;

        if (mode == MODE_MANUAL) begin
            // Manual wins from any state; hold is irrelevant here.
            state_d = MANUAL;
            ch_d    = sel;
            if (sel_in_range) begin
                cur_ch_d = sel;
                data_d   = chan_data[sel];
                valid_d  = in_valid[sel];
            end
        end else begin
            case (state_q)
                MANUAL: begin
                    state_d  = SCAN;
                    cur_ch_d = sel_in_range ? sel : '0;
                    dcnt_d   = DWELL_RELOAD;
                end
                SCAN, HOLD: begin
                    // A hold sampled in SCAN lets this edge count and freezes
                    // the following ones; the edge that releases HOLD counts
                    // again, so the pause lasts one cycle less than hold.
                    if (state_q == SCAN || !hold) begin
                        if (dcnt_q == '0) begin
                            dcnt_d = DWELL_RELOAD;
                            if (pick_found) begin
                                cur_ch_d = pick_ch;
                            end
                        end else begin
                            dcnt_d = dcnt_q - 1'b1;
                        end
                        pulse_d = (cur_ch_d != cur_ch_q);
                    end
                    state_d = hold ? HOLD : SCAN;
                end
                default: state_d = MANUAL;
            endcase
            // Outputs present the channel that cur_ch holds after this edge,
            // so out_ch and switch_pulse line up with the new channel.
            ch_d    = cur_ch_d;
            data_d  = chan_data[cur_ch_d];
            valid_d = in_valid[cur_ch_d];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= MANUAL;
            cur_ch_q     <= '0;
            dcnt_q       <= '0;
            out_data     <= '0;
            out_valid    <= 1'b0;
            out_ch       <= '0;
            switch_pulse <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q      <= state_d;
            cur_ch_q     <= cur_ch_d;
            dcnt_q       <= dcnt_d;
            out_data     <= data_d;
            out_valid    <= valid_d;
            out_ch       <= ch_d;
            switch_pulse <= pulse_d;
        end
    end

endmodule

// File: tb/tb_mux_n_scan.sv
// -----------------------------------------------------------------------------
// tb_mux_n_scan
// Two instances share one stimulus stream: a 4-channel block with DWELL=3 and
// a 3-channel block with DWELL=1 (out-of-range sel and every-cycle scan).
// The driver pushes the reference model's prediction per edge into a queue;
// a monitor pops and compares on each falling edge.
// -----------------------------------------------------------------------------
module tb_mux_n_scan;

    localparam logic [31:0] ALL = 32'hDDCCBBAA;

    typedef struct packed {
        logic [7:0] data;
        logic       valid;
        logic [1:0] ch;
        logic       pulse;
    } obs_t;

    typedef struct packed {
        obs_t a;
        obs_t b;
    } exp_t;

    // Reference model state: what the scanner is doing in plain terms.
    typedef struct {
        bit scanning;
        bit paused;
        int chan;
        int left;
    } mstate_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_data = ALL;
    logic [3:0]  in_valid = 4'hF;
    logic        mode = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic        hold = 1'b0;

    logic [7:0]  a_data, b_data;
    logic        a_valid, b_valid, a_pulse, b_pulse;
    logic [1:0]  a_ch, b_ch;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    mstate_t ms[2];
    int nch[2] = '{4, 3};
    int dwl[2] = '{3, 1};

    always #5 clk = ~clk;

    mux_n_scan #(.WIDTH(8), .CHANNELS(4), .DWELL(3)) dut_a (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .mode         (mode),
        .sel          (sel),
        .hold         (hold),
        .out_data     (a_data),
        .out_valid    (a_valid),
        .out_ch       (a_ch),
        .switch_pulse (a_pulse)
    );

    mux_n_scan #(.WIDTH(8), .CHANNELS(3), .DWELL(1)) dut_b (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data[23:0]),
        .in_valid     (in_valid[2:0]),
        .mode         (mode),
        .sel          (sel),
        .hold         (hold),
        .out_data     (b_data),
        .out_valid    (b_valid),
        .out_ch       (b_ch),
        .switch_pulse (b_pulse)
    );

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {data,valid,ch,pulse}=%h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            ms[d].scanning = 1'b0;
            ms[d].paused   = 1'b0;
            ms[d].chan     = 0;
            ms[d].left     = 0;
        end
    endfunction

    // Result of one rising edge for instance d, given that edge's inputs.
    function automatic obs_t model_step(input int d, input bit m, input int s,
                                        input bit h, input logic [3:0] v,
                                        input logic [31:0] data);
        obs_t o;
        int   n;
        int   prev;
        int   c;
        o = '0;
        n = nch[d];
        if (!m) begin
            ms[d].scanning = 1'b0;
            ms[d].paused   = 1'b0;
            o.ch = 2'(s);
            if (s < n) begin
                ms[d].chan = s;
                o.data  = 8'(data >> (8 * s));
                o.valid = v[2'(s)];
            end
            return o;
        end
        prev = ms[d].chan;
        if (!ms[d].scanning) begin
            ms[d].scanning = 1'b1;
            ms[d].paused   = 1'b0;
            ms[d].chan     = (s < n) ? s : 0;
            ms[d].left     = dwl[d] - 1;
        end else begin
            if (!(ms[d].paused && h)) begin
                if (ms[d].left == 0) begin
                    ms[d].left = dwl[d] - 1;
                    for (int k = 1; k < n; k++) begin
                        c = (prev + k) % n;
                        if (v[2'(c)]) begin
                            ms[d].chan = c;
                            break;
                        end
                    end
                end else begin
                    ms[d].left--;
                end
            end
            ms[d].paused = h;
            o.pulse = (ms[d].chan != prev);
        end
        o.ch    = 2'(ms[d].chan);
        o.data  = 8'(data >> (8 * ms[d].chan));
        o.valid = v[2'(ms[d].chan)];
        return o;
    endfunction

    // Apply inputs for the next rising edge and record the prediction.
    task automatic drive(input bit m, input logic [1:0] s, input bit h,
                         input logic [3:0] v, input logic [31:0] d);
        exp_t e;
        mode     = m;
        sel      = s;
        hold     = h;
        in_valid = v;
        in_data  = d;
        e.a = model_step(0, m, int'(s), h, v, d);
        e.b = model_step(1, m, int'(s), h, v, d);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_a"}, {a_data, a_valid, a_ch, a_pulse}, 12'h000);
        check({tag, "_b"}, {b_data, b_valid, b_ch, b_pulse}, 12'h000);
    endtask

    // Reset between edges: outputs must clear before any clock edge arrives.
    task automatic pulse_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_zero("rst_async");
        model_reset();
        @(posedge clk);
        #1;
        check_zero("rst_held");
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: every falling edge after a predicted rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("obs_a", {a_data, a_valid, a_ch, a_pulse}, e.a);
                check("obs_b", {b_data, b_valid, b_ch, b_pulse}, e.b);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit m;
        model_reset();
        #2;
        check_zero("rst_init");
        repeat (2) @(posedge clk);
        #1;
        check_zero("rst_init_held");
        @(negedge clk);
        rst = 1'b0;

        // Manual selection over every index, including out of range for b.
        for (int s = 0; s < 4; s++) drive(1'b0, 2'(s), 1'b0, 4'hF, ALL);
        drive(1'b0, 2'd2, 1'b1, 4'b1011, ALL);
        drive(1'b0, 2'd3, 1'b0, 4'b0111, ALL);

        // Scan from channel 1 over all-valid inputs.
        repeat (10) drive(1'b1, 2'd1, 1'b0, 4'hF, ALL);
        drive(1'b0, 2'd0, 1'b0, 4'hF, ALL);

        // Sparse valid: channels 1 and 2 skipped.
        repeat (8) drive(1'b1, 2'd0, 1'b0, 4'b1001, ALL);
        drive(1'b0, 2'd0, 1'b0, 4'hF, ALL);

        // Only channel 2 valid: position sticks, no pulses.
        repeat (10) drive(1'b1, 2'd2, 1'b0, 4'b0100, ALL);
        drive(1'b0, 2'd0, 1'b0, 4'hF, ALL);

        // Out-of-range start point falls back to channel 0.
        repeat (4) drive(1'b1, 2'd3, 1'b0, 4'hF, ALL);
        drive(1'b0, 2'd0, 1'b0, 4'hF, ALL);

        // Hold on the second dwell cycle of channel 1, then back to manual.
        repeat (5) drive(1'b1, 2'd0, 1'b0, 4'hF, ALL);
        repeat (5) drive(1'b1, 2'd0, 1'b1, 4'hF, ALL);
        repeat (3) drive(1'b1, 2'd0, 1'b0, 4'hF, ALL);
        repeat (2) drive(1'b0, 2'd0, 1'b0, 4'hF, ALL);

        // Manual overrides an active hold.
        repeat (2) drive(1'b1, 2'd1, 1'b0, 4'hF, ALL);
        repeat (3) drive(1'b1, 2'd1, 1'b1, 4'hF, ALL);
        drive(1'b0, 2'd2, 1'b1, 4'hF, ALL);

        // Reset in the middle of a scan, then manual follows sel.
        repeat (4) drive(1'b1, 2'd1, 1'b0, 4'hF, ALL);
        pulse_reset();
        drive(1'b0, 2'd3, 1'b0, 4'hF, ALL);
        drive(1'b0, 2'd1, 1'b0, 4'hF, ALL);

        // Randomized traffic.
        m = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(15) == 0) m = ~m;
            if (i == 200) pulse_reset();
            drive(m, 2'($urandom_range(3)), ($urandom_range(3) == 0),
                  4'($urandom), $urandom);
        end

        for (int w = 0; w < 5 && sb.size() > 0; w++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending entries expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_n_scan.md
MUX_N_SCAN -- requirements
Module: mux_n_scan

Interface
- REQ-001: Parameter WIDTH, default 8, data bits per channel; legal range 1..32.
- REQ-002: Parameter CHANNELS, default 4, number of input channels; legal range 2..16.
- REQ-003: Parameter DWELL, default 4, cycles spent on each channel in scan mode; legal range 1..255.
- REQ-004: Derived constant SELW = max(1, clog2(CHANNELS)), width of every channel index.
- REQ-005: clk  input  1  single clock; every register updates on its rising edge.
- REQ-006: rst  input  1  reset, asynchronous, active-high.
- REQ-007: in_data  input  CHANNELS*WIDTH  channel data, packed; channel k occupies bits [k*WIDTH +: WIDTH].
- REQ-008: in_valid  input  CHANNELS  per-channel valid flag.
- REQ-009: mode  input  1  0 = MANUAL (follow sel), 1 = SCAN (automatic round-robin).
- REQ-010: sel  input  SELW  channel index used in MANUAL mode, and as the scan start point.
- REQ-011: hold  input  1  freezes the scan position while in SCAN mode.
- REQ-012: out_data  output  WIDTH  registered data of the selected channel.
- REQ-013: out_valid  output  1  registered in_valid of the selected channel.
- REQ-014: out_ch  output  SELW  registered index of the selected channel.
- REQ-015: switch_pulse  output  1  one-cycle pulse when the scan moves to a different channel.

Function
- REQ-016: The block SHALL hold a state register with states MANUAL, SCAN and HOLD, a channel register cur_ch and a dwell counter dcnt (8 bits).
- REQ-017: MANUAL: each cycle cur_ch <= sel; out_data/out_valid/out_ch SHALL take in_data[sel], in_valid[sel] and sel (1-cycle latency).
- REQ-018: MANUAL with sel >= CHANNELS: out_data = 0, out_valid = 0, out_ch = sel, cur_ch unchanged.
- REQ-019: MANUAL -> SCAN when mode=1 SHALL load cur_ch <= sel (in range) or 0 (out of range), and load dcnt <= DWELL-1.
- REQ-020: SCAN: outputs SHALL register in_data[cur_ch], in_valid[cur_ch] and cur_ch every cycle; dcnt decrements by 1 per cycle.
- REQ-021: SCAN with dcnt = 0: cur_ch <= first index after cur_ch (ascending, wrapping CHANNELS-1 -> 0) whose in_valid is 1 in that cycle; dcnt <= DWELL-1.
- REQ-022: When no other channel is valid at dcnt = 0, cur_ch SHALL stay unchanged, dcnt reloads, and no pulse is issued.
- REQ-023: switch_pulse SHALL be 1 for exactly the cycle after cur_ch changes in SCAN; it is 0 in MANUAL and HOLD.
- REQ-024: SCAN -> HOLD when hold=1; in HOLD, cur_ch and dcnt are frozen and outputs keep sampling cur_ch.
- REQ-025: HOLD -> SCAN when hold=0; counting resumes from the frozen dcnt.
- REQ-026: mode=0 SHALL force MANUAL from SCAN or HOLD on the next edge, regardless of hold; hold is ignored in MANUAL.
- REQ-027: With DWELL=1, the scan SHALL advance every cycle.

Reset
- REQ-028: While rst=1: state = MANUAL, cur_ch = 0, dcnt = 0, out_data = 0, out_valid = 0, out_ch = 0, switch_pulse = 0.
- REQ-029: Reset asserted mid-scan SHALL abort the scan immediately; after release the block follows REQ-017 on the first edge.

Structure
- REQ-030: Shared package mux_pkg SHALL hold the state enumeration (MANUAL, SCAN, HOLD) and the mode encoding constants.
- REQ-031: A combinational sub-module mux_rr_pick (inputs: valid vector and current index; outputs: next index and found flag) SHALL implement the wrapping search of REQ-021/REQ-022.
- REQ-032: No latches; all outputs are driven directly from registers.

Verification (WIDTH=8, CHANNELS=4, DWELL=3, in_data = {8'hDD, 8'hCC, 8'hBB, 8'hAA}, all valid unless stated)
- REQ-033: MANUAL, sel=2 -> next cycle out_data=8'hCC, out_ch=2, out_valid=1; sel=5 with CHANNELS=5 not legal, so test sel out of range with CHANNELS=3, sel=3 -> out_data=0, out_valid=0.
- REQ-034: mode=1 with sel=1 -> out_ch sequence 1,1,1,2,2,2,3,3,3,0; switch_pulse high on the first cycle of each new channel.
- REQ-035: SCAN with in_valid=4'b1001 starting at ch0 -> out_ch sequence 0,0,0,3,3,3,0; channels 1 and 2 are skipped.
- REQ-036: SCAN with only ch2 valid -> out_ch stays 2 indefinitely; switch_pulse stays 0.
- REQ-037: hold=1 for 5 cycles on the second dwell cycle of ch1 -> ch1 is held 7 cycles total; then mode=0 with sel=0 -> out_ch=0 on the next cycle.
- REQ-038: rst pulse mid-scan -> all outputs are 0 asynchronously; after release out_ch follows sel.
